apb_req_arbiter: RTL

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_req_arbiter_if.sv | 35 +++
 rtl/apb_req_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter_if.sv
// Bridge-side bus of the request arbiter: a single-transfer handshake where the
// arbiter drives the command and the bridge answers with ready/data_out.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef STRB_SIZE
`define STRB_SIZE 4
`endif

interface apb_req_arbiter_if #(
    parameter int AW = `ADDR_WIDTH,
    parameter int DW = `DATA_WIDTH,
    parameter int SW = `STRB_SIZE
);
    logic          trnsfr;
    logic          wr;
    logic [SW-1:0] strb;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          ready;

    modport master (
        output trnsfr, wr, strb, address, data_in,
        input  data_out, ready
    );

    modport slave (
        input  trnsfr, wr, strb, address, data_in,
        output data_out, ready
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter funnelling NREQ requesters onto one bridge master port,
// one single transfer at a time, with a WAIT timeout that aborts hung transfers.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef STRB_SIZE
`define STRB_SIZE 4
`endif

module apb_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = `ADDR_WIDTH,
    parameter int DW      = `DATA_WIDTH,
    parameter int SW      = `STRB_SIZE,
    parameter int TIMEOUT = 16,
    localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW     = $clog2(TIMEOUT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [NREQ*SW-1:0] req_strb,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_done,
    output logic               req_err,
    output logic [DW-1:0]      req_rdata,
    output logic               busy,
    output logic [IW-1:0]      grant_id,
    apb_req_arbiter_if.master  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   rr_ptr, rr_ptr_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [IW-1:0]   grant_id_n;
    logic            trnsfr_q, trnsfr_n;
    logic            wr_q, wr_n;
    logic [SW-1:0]   strb_q, strb_n;
    logic [AW-1:0]   addr_q, addr_n;
    logic [DW-1:0]   wdata_q, wdata_n;
    logic [NREQ-1:0] done_n;
    logic            err_n;
    logic [DW-1:0]   rdata_n;
    logic            busy_n;

    logic [IW-1:0]   pick, cand;
    logic            found;

    // First requesting index at or above rr_ptr, wrapping past NREQ-1.
    always_comb begin
        pick  = rr_ptr;
        cand  = rr_ptr;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(rr_ptr) + i) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_n    = state;
        rr_ptr_n   = rr_ptr;
        cnt_n      = cnt;
        grant_id_n = grant_id;
        trnsfr_n   = 1'b0;
        wr_n       = wr_q;
        strb_n     = strb_q;
        addr_n     = addr_q;
        wdata_n    = wdata_q;
        done_n     = '0;
        err_n      = 1'b0;
        rdata_n    = req_rdata;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n    = ISSUE;
                    grant_id_n = pick;
                    wr_n       = req_wr[pick];
                    strb_n     = req_strb[int'(pick)*SW +: SW];
                    addr_n     = req_addr[int'(pick)*AW +: AW];
                    wdata_n    = req_wdata[int'(pick)*DW +: DW];
                    trnsfr_n   = 1'b1;
                    cnt_n      = '0;
                end
            end
            ISSUE: state_n = WAIT;
            WAIT: begin
                if (bus.ready) begin
                    rdata_n          = bus.data_out;
                    done_n[grant_id] = 1'b1;
                    state_n          = RELEASE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    // Abort: completion reported with error, read data kept.
                    done_n[grant_id] = 1'b1;
                    err_n            = 1'b1;
                    state_n          = RELEASE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (!bus.ready) begin
                    state_n  = IDLE;
                    rr_ptr_n = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            grant_id  <= '0;
            trnsfr_q  <= 1'b0;
            wr_q      <= 1'b0;
            strb_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            req_done  <= '0;
            req_err   <= 1'b0;
            req_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            cnt       <= cnt_n;
            grant_id  <= grant_id_n;
            trnsfr_q  <= trnsfr_n;
            wr_q      <= wr_n;
            strb_q    <= strb_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            req_done  <= done_n;
            req_err   <= err_n;
            req_rdata <= rdata_n;
            busy      <= busy_n;
        end
    end

    assign bus.trnsfr  = trnsfr_q;
    assign bus.wr      = wr_q;
    assign bus.strb    = strb_q;
    assign bus.address = addr_q;
    assign bus.data_in = wdata_q;

endmodule
